bus_responder: RTL

- Target side of the 6502 core's memory bus: services every CPU read and write.
- Contains on-chip RAM, an I/O page with an 8-bit keyboard scancode FIFO and a 16-bit reloadable down-timer with interrupt.
- Returns registered read data, so data is valid one clock after the address is presented, matching the core's synchronous-RAM timing.
- Sits between the cpu core and the board peripherals, inside the top level.

---
 rtl/bus_responder_if.sv | 39 +++
 rtl/bus_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder_if.sv
// bus_responder_if: CPU-side memory bus plus keyboard strobe and interrupt
// line between the 6502 core (master) and bus_responder (slave).
//
// Signals:
//   address  16  CPU bus address
//   wdata     8  CPU write data
//   wren      1  write strobe, one cycle
//   read      1  read strobe, only gates read side effects
//   rdata     8  registered read data, valid one clock after address
//   kb_data   8  keyboard scancode
//   kb_hit    1  one-cycle strobe that pushes kb_data
//   irq       1  timer interrupt request, level
//
// Handshake semantics: there is no valid/ready pair on this bus. Every clock
// is a bus cycle: the slave samples address/wdata/wren/read/kb_* on each
// rising edge and always presents the data for that address on rdata after
// the same edge. wren and kb_hit act for exactly the cycle they are high;
// read only enables side effects (FIFO pop, overflow clear, shadow latch);
// wren together with read is treated as a write with no read side effects.
interface bus_responder_if;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        wren;
  logic        read;
  logic [7:0]  rdata;
  logic [7:0]  kb_data;
  logic        kb_hit;
  logic        irq;

  modport master (
    output address, wdata, wren, read, kb_data, kb_hit,
    input  rdata, irq
  );

  modport slave (
    input  address, wdata, wren, read, kb_data, kb_hit,
    output rdata, irq
  );
endinterface

// File: rtl/bus_responder.sv
// bus_responder: target side of the 6502 core's memory bus. Holds on-chip
// RAM, and an I/O page at 0xC000..0xC0FF with a keyboard scancode FIFO and a
// 16-bit reloadable down-timer with interrupt. Read data is registered so it
// appears one clock after the address, like synchronous RAM.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of bus_responder_if (address, wdata, wren, read,
//                 rdata, kb_data, kb_hit, irq)
//
// I/O page offsets (address[7:0]):
//   0x00 KSTAT  R   {overflow, 5'b0, full, not_empty}; read clears overflow
//   0x01 KDATA  R   FIFO head; read pops when not empty, empty reads 0x00
//   0x02 TLO    R   count[7:0]; read latches count[15:8] into shadow
//   0x03 THI    R   shadow
//   0x04 TCTL   RW  {flag, 5'b0, irq_en, enable}; write bit7=1 clears flag
//   0x05 RLO    RW  reload[7:0]
//   0x06 RHI    RW  reload[15:8]; write also loads count
module bus_responder #(
  parameter int RAM_AW   = 15,
  parameter int FIFO_AW  = 3,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  bus_responder_if.slave bus
);

  localparam int RAM_DEPTH  = 1 << RAM_AW;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]      PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   OCC_ONE   = (FIFO_AW + 1)'(1);

  localparam logic [7:0] OFF_KSTAT = 8'h00;
  localparam logic [7:0] OFF_KDATA = 8'h01;
  localparam logic [7:0] OFF_TLO   = 8'h02;
  localparam logic [7:0] OFF_THI   = 8'h03;
  localparam logic [7:0] OFF_TCTL  = 8'h04;
  localparam logic [7:0] OFF_RLO   = 8'h05;
  localparam logic [7:0] OFF_RHI   = 8'h06;

  // ---------------------------------------------------------------------
  // Address decode. The I/O page wins over RAM if RAM is large enough to
  // overlap it.
  // ---------------------------------------------------------------------
  logic              io_sel;
  logic              ram_sel;
  logic [7:0]        io_off;
  logic [RAM_AW-1:0] ram_addr;

  assign io_sel   = (bus.address[15:8] == 8'hC0);
  assign ram_sel  = !io_sel && ({1'b0, bus.address} < 17'(RAM_DEPTH));
  assign io_off   = bus.address[7:0];
  assign ram_addr = bus.address[RAM_AW-1:0];

  // A write strobe overrides read: no read side effects in that cycle.
  logic rd_fx;
  assign rd_fx = bus.read && !bus.wren;

  logic io_wr;
  assign io_wr = bus.wren && io_sel;

  logic kstat_rd, kdata_rd, tlo_rd;
  logic wr_tctl, wr_rlo, wr_rhi;

  assign kstat_rd = rd_fx && io_sel && (io_off == OFF_KSTAT);
  assign kdata_rd = rd_fx && io_sel && (io_off == OFF_KDATA);
  assign tlo_rd   = rd_fx && io_sel && (io_off == OFF_TLO);
  assign wr_tctl  = io_wr && (io_off == OFF_TCTL);
  assign wr_rlo   = io_wr && (io_off == OFF_RLO);
  assign wr_rhi   = io_wr && (io_off == OFF_RHI);

  // ---------------------------------------------------------------------
  // RAM. Kept free of reset so it maps onto block RAM; the read port is
  // registered here and muxed with the registered I/O value below.
  // ---------------------------------------------------------------------
  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] ram_q;

  always_ff @(posedge clock) begin
    if (reset_n && bus.wren && ram_sel) begin
      ram[ram_addr] <= bus.wdata;
    end
    ram_q <= ram[ram_addr];
  end

  // ---------------------------------------------------------------------
  // Keyboard FIFO
  // ---------------------------------------------------------------------
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   occ;
  logic               kb_ovf;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FIFO_FULL);
  assign pop        = kdata_rd && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push       = bus.kb_hit && (!fifo_full || pop);
  assign drop       = bus.kb_hit && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      fifo_mem[wptr] <= bus.kb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------
  logic [15:0]   count;
  logic [15:0]   reload;
  logic [15:0]   count_nxt;
  logic [PW-1:0] presc;
  logic [7:0]    shadow;
  logic          t_en;
  logic          t_ie;
  logic          t_flag;
  logic          tick;
  logic          flag_set;
  logic          irq_q;

  assign tick     = t_en && (presc == PS_LAST);
  assign flag_set = tick && (count == 16'h0000);

  // An RHI write is an explicit load and takes priority over a tick.
  always_comb begin
    count_nxt = count;
    if (tick) begin
      count_nxt = (count == 16'h0000) ? reload : (count - 16'd1);
    end
    if (wr_rhi) begin
      count_nxt = {bus.wdata, reload[7:0]};
    end
  end

  // ---------------------------------------------------------------------
  // Read data for the I/O page and unmapped space, sampled from the state
  // before this edge's updates.
  // ---------------------------------------------------------------------
  logic [7:0] io_val;

  always_comb begin
    io_val = 8'hFF;
    if (io_sel) begin
      case (io_off)
        OFF_KSTAT: io_val = {kb_ovf, 5'b00000, fifo_full, !fifo_empty};
        OFF_KDATA: io_val = fifo_empty ? 8'h00 : fifo_mem[rptr];
        OFF_TLO:   io_val = count[7:0];
        OFF_THI:   io_val = shadow;
        OFF_TCTL:  io_val = {t_flag, 5'b00000, t_ie, t_en};
        OFF_RLO:   io_val = reload[7:0];
        OFF_RHI:   io_val = reload[15:8];
        default:   io_val = 8'hFF;
      endcase
    end
  end

  logic [7:0] io_q;
  logic       ram_hit_q;

  // ---------------------------------------------------------------------
  // Control/status registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      kb_ovf    <= 1'b0;
      count     <= 16'h0000;
      reload    <= 16'hFFFF;
      presc     <= '0;
      t_en      <= 1'b0;
      t_ie      <= 1'b0;
      t_flag    <= 1'b0;
      shadow    <= 8'h00;
      irq_q     <= 1'b0;
      io_q      <= 8'h00;
      ram_hit_q <= 1'b0;
    end else begin
      io_q      <= io_val;
      ram_hit_q <= ram_sel;

      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase

      // A new drop in the same cycle as a KSTAT read stays visible.
      if (drop) begin
        kb_ovf <= 1'b1;
      end else if (kstat_rd) begin
        kb_ovf <= 1'b0;
      end

      if (tlo_rd) shadow <= count[15:8];

      if (t_en) begin
        presc <= tick ? '0 : (presc + PW'(1));
      end
      count <= count_nxt;

      if (wr_tctl) begin
        t_en <= bus.wdata[0];
        t_ie <= bus.wdata[1];
      end
      // Setting the flag beats a simultaneous clear request.
      if (flag_set) begin
        t_flag <= 1'b1;
      end else if (wr_tctl && bus.wdata[7]) begin
        t_flag <= 1'b0;
      end

      if (wr_rlo) reload[7:0]  <= bus.wdata;
      if (wr_rhi) reload[15:8] <= bus.wdata;

      irq_q <= t_flag && t_ie;
    end
  end

  // Both sources are registers; this mux only picks which one was addressed
  // on the previous edge. After reset ram_hit_q=0 and io_q=0, so rdata=0x00.
  assign bus.rdata = ram_hit_q ? ram_q : io_q;
  assign bus.irq   = irq_q;

endmodule
